univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 19 +
 rtl/ser_counter.sv | 25 ++
 rtl/univ_shift_reg.sv | 112 +++++++++++
 tb/tb_univ_shift_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the serializer state type.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASHR = 3'b110;
    localparam logic [2:0] MODE_SER  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ser_state_e;

endpackage

// File: rtl/ser_counter.sv
// Serializer bit counter: counts shifted bits 0..n-1 and flags the last one.
module ser_counter #(
    parameter int n = 8,
    localparam int CW = $clog2(n)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + CW'(1);
    end

    assign last = (count == CW'(n - 1));

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with load/shift/rotate modes and an MSB-first
// serializer that streams a parallel word out over n enabled cycles.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic [n-1:0] a,
    input  logic         sin_l,
    input  logic         sin_r,
    output logic [n-1:0] q,
    output logic         sout_msb,
    output logic         sout_lsb,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(n);

    ser_state_e    state, state_nxt;
    logic [n-1:0]  q_nxt;
    logic          done_nxt;
    logic          cnt_clr, cnt_inc, cnt_last;
    logic [CW-1:0] cnt;
    logic          cnt_unused;

    ser_counter #(.n(n)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt),
        .last  (cnt_last)
    );

    // Only the terminal flag drives control; the raw count is observability.
    assign cnt_unused = ^cnt;

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        done_nxt  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    case (mode)
                        MODE_LOAD: q_nxt = a;
                        MODE_SHL:  q_nxt = {q[n-2:0], sin_r};
                        MODE_SHR:  q_nxt = {sin_l, q[n-1:1]};
                        MODE_ROTL: q_nxt = {q[n-2:0], q[n-1]};
                        MODE_ROTR: q_nxt = {q[0], q[n-1:1]};
                        MODE_ASHR: q_nxt = {q[n-1], q[n-1:1]};
                        MODE_SER: begin
                            q_nxt     = a;
                            state_nxt = ST_BUSY;
                            cnt_clr   = 1'b1;
                        end
                        default:   q_nxt = q;
                    endcase
                end
            end
            ST_BUSY: begin
                // Inputs other than en are ignored until the word is out.
                if (en) begin
                    q_nxt = {q[n-2:0], 1'b0};
                    if (cnt_last) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else
            q <= q_nxt;
    end

    // done_nxt is only set on the completing edge, so the pulse self-clears
    // on the next edge whatever en does.
    always_ff @(posedge clk) begin
        if (rst)
            done <= 1'b0;
        else
            done <= done_nxt;
    end

    assign busy     = (state == ST_BUSY);
    assign sout_msb = q[n-1];
    assign sout_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (n=8): per-cycle model comparison plus
// literal expectations for each operation and serializer scenario.
module tb_univ_shift_reg;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, sin_l, sin_r;
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] q;
    logic       sout_msb, sout_lsb, busy, done;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    logic [7:0] m_q    = '0;
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         m_left = 0;

    univ_shift_reg #(.n(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .a        (a),
        .sin_l    (sin_l),
        .sin_r    (sin_r),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a serialize run is "m_left shifts still to go".
    always @(posedge clk) begin
        if (rst) begin
            m_q = '0; m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (en && m_busy) begin
                m_q = m_q << 1;
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (en) begin
                case (mode)
                    3'd1: m_q = a;
                    3'd2: m_q = (m_q << 1) | {7'd0, sin_r};
                    3'd3: m_q = (m_q >> 1) | {sin_l, 7'd0};
                    3'd4: m_q = (m_q << 1) | (m_q >> 7);
                    3'd5: m_q = (m_q >> 1) | (m_q << 7);
                    3'd6: m_q = 8'($signed(m_q) >>> 1);
                    3'd7: begin m_q = a; m_busy = 1; m_left = 8; end
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_on) begin
            chk("cyc_q", q, m_q);
            chk("cyc_msb", sout_msb, m_q[7]);
            chk("cyc_lsb", sout_lsb, m_q[0]);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] d);
        mode = m; a = d; tick();
    endtask

    // Runs from the first busy cycle until done is seen, recording the bit
    // shifted out on each enabled busy cycle; en is dropped over a window.
    task automatic collect(input int pause_at, input int pause_len,
                           output logic [15:0] bits, output int nbits,
                           output int nbusy, output bit got_done);
        bits = '0; nbits = 0; nbusy = 0; got_done = 0;
        mode = MODE_LOAD; a = 8'h55; sin_l = 1; sin_r = 1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            en = !(pause_len > 0 && i >= pause_at && i < pause_at + pause_len);
            if (busy) nbusy++;
            if (busy && en) begin
                bits = {bits[14:0], sout_msb};
                nbits++;
            end
            tick();
        end
        en = 1;
        if (!got_done) chk("ser_timeout", 0, 1);
    endtask

    logic [15:0] bits;
    int          nbits, nbusy;
    bit          got_done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; en = 0; mode = MODE_HOLD; a = '0; sin_l = 0; sin_r = 0;
        tick();
        cmp_on = 1;
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        en = 1; mode = MODE_LOAD; a = 8'hFF;
        tick();
        chk("rst_override_q", q, 8'h00);

        rst = 0;
        op(MODE_LOAD, 8'hA5);       chk("load_a5", q, 8'hA5);
        op(MODE_HOLD, 8'h00);       chk("hold", q, 8'hA5);
        en = 0; op(MODE_LOAD, 8'h3C); chk("en_low_hold", q, 8'hA5);
        en = 1;

        sin_r = 1; sin_l = 1;
        op(MODE_LOAD, 8'h81); op(MODE_SHL, 8'h00);  chk("shl", q, 8'h03);
        op(MODE_LOAD, 8'h81); op(MODE_SHR, 8'h00);  chk("shr", q, 8'hC0);
        sin_r = 0; sin_l = 0;
        op(MODE_LOAD, 8'h81); op(MODE_ROTL, 8'h00); chk("rotl", q, 8'h03);
        op(MODE_LOAD, 8'h81); op(MODE_ROTR, 8'h00); chk("rotr", q, 8'hC0);
        op(MODE_LOAD, 8'h80); op(MODE_ASHR, 8'h00); chk("ashr", q, 8'hC0);
        op(MODE_LOAD, 8'h81); op(MODE_SHL, 8'h00);  chk("shl_fill0", q, 8'h02);

        // Plain serialize of 0xB4
        op(MODE_SER, 8'hB4);
        chk("ser_start_busy", busy, 1);
        chk("ser_start_q", q, 8'hB4);
        collect(-1, 0, bits, nbits, nbusy, got_done);
        chk("b4_bits", bits[7:0], 8'hB4);
        chk("b4_nbits", nbits, 8);
        chk("b4_nbusy", nbusy, 8);
        chk("b4_q_after", q, 8'h00);
        mode = MODE_HOLD; tick();
        chk("b4_done_once", done, 0);

        // 0xFF with en low for three mid-sequence cycles; en also low on done cycle
        op(MODE_SER, 8'hFF);
        collect(3, 3, bits, nbits, nbusy, got_done);
        chk("ff_bits", bits[7:0], 8'hFF);
        chk("ff_nbits", nbits, 8);
        chk("ff_nbusy", nbusy, 11);
        en = 0; mode = MODE_HOLD; tick();
        chk("ff_done_en_low", done, 0);
        en = 1;

        // Reset at busy cycle 4 aborts with no done pulse
        op(MODE_SER, 8'hB4);
        mode = MODE_HOLD; tick(); tick(); tick();
        chk("abort_busy_pre", busy, 1);
        rst = 1; tick();
        chk("abort_q", q, 8'h00);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 0; tick();
        chk("abort_no_done", done, 0);
        op(MODE_LOAD, 8'h3C); chk("abort_reload", q, 8'h3C);

        // Back-to-back: new start on the done cycle
        op(MODE_SER, 8'hB4);
        collect(-1, 0, bits, nbits, nbusy, got_done);
        chk("b2b_first", bits[7:0], 8'hB4);
        op(MODE_SER, 8'h0F);
        chk("b2b_restart_busy", busy, 1);
        collect(-1, 0, bits, nbits, nbusy, got_done);
        chk("b2b_bits", bits[7:0], 8'h0F);
        chk("b2b_nbusy", nbusy, 8);
        mode = MODE_HOLD; tick();
        tick();

        cmp_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
